// File: rtl/fixed_mha_score.sv
// Multi-head attention score engine.
// K head vectors for one sequence are buffered first. Each Q head vector that
// follows is dotted against every buffered K vector of the same head. The
// result is one row of scaled, saturated and optionally causal-masked scores.
module fixed_mha_score #(
  parameter int IN_WIDTH       = 8,
  parameter int IN_FRAC_WIDTH  = 1,
  parameter int OUT_WIDTH      = 8,
  parameter int OUT_FRAC_WIDTH = 2,
  parameter int NUM_HEADS      = 2,
  parameter int SEQ_LEN        = 4,
  parameter int HEAD_DIM       = 2,
  parameter int SCALE_SHIFT    = 1,
  parameter int CAUSAL         = 0,
  localparam int HW            = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1,
  localparam int SW            = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_WIDTH*HEAD_DIM-1:0]  data_in_k,
  input  logic                          data_in_k_valid,
  output logic                          data_in_k_ready,
  input  logic [IN_WIDTH*HEAD_DIM-1:0]  data_in_q,
  input  logic                          data_in_q_valid,
  output logic                          data_in_q_ready,
  output logic [OUT_WIDTH*SEQ_LEN-1:0]  data_out,
  output logic [HW-1:0]                 data_out_head,
  output logic [SW-1:0]                 data_out_row,
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic                          k_loaded
);

  localparam int ACC_W = 2*IN_WIDTH + $clog2(HEAD_DIM);
  localparam int SHIFT = 2*IN_FRAC_WIDTH + SCALE_SHIFT - OUT_FRAC_WIDTH;
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {LOAD_K, WAIT_Q, COMPUTE, OUTPUT} state_t;

  state_t r_state, w_next;

  logic [IN_WIDTH*HEAD_DIM-1:0] r_kbuf [SEQ_LEN][NUM_HEADS];
  logic [IN_WIDTH*HEAD_DIM-1:0] r_q;
  logic [OUT_WIDTH*SEQ_LEN-1:0] r_row;
  logic [SW-1:0]                r_k_tok, r_q_tok, r_j, r_out_row;
  logic [HW-1:0]                r_k_head, r_q_head, r_out_head;

  logic                         w_k_fire, w_q_fire, w_out_fire;
  logic                         w_k_last, w_q_last, w_j_last;
  logic [IN_WIDTH*HEAD_DIM-1:0] w_kvec;
  logic signed [2*IN_WIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0]      w_acc, w_shift;
  logic [OUT_WIDTH-1:0]         w_score;

  assign w_k_fire   = data_in_k_valid & data_in_k_ready;
  assign w_q_fire   = data_in_q_valid & data_in_q_ready;
  assign w_out_fire = data_out_valid & data_out_ready;
  assign w_k_last   = (r_k_tok == SW'(SEQ_LEN-1)) && (r_k_head == HW'(NUM_HEADS-1));
  assign w_q_last   = (r_q_tok == SW'(SEQ_LEN-1)) && (r_q_head == HW'(NUM_HEADS-1));
  assign w_j_last   = (r_j == SW'(SEQ_LEN-1));

  assign data_out      = r_row;
  assign data_out_head = r_out_head;
  assign data_out_row  = r_out_row;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= LOAD_K;
    else      r_state <= w_next;
  end

  // Next-state and state-decoded outputs; readies never look at valid.
  // NOTE: every output gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    w_next          = r_state;
    data_in_k_ready = 1'b0;
    data_in_q_ready = 1'b0;
    data_out_valid  = 1'b0;
    k_loaded        = 1'b1;
    case (r_state)
      LOAD_K: begin
        data_in_k_ready = 1'b1;
        k_loaded        = 1'b0;
        if (w_k_fire && w_k_last) w_next = WAIT_Q;
      end
      WAIT_Q: begin
        data_in_q_ready = 1'b1;
        if (w_q_fire) w_next = COMPUTE;
      end
      COMPUTE: begin
        if (w_j_last) w_next = OUTPUT;
      end
      OUTPUT: begin
        data_out_valid = 1'b1;
        if (data_out_ready) w_next = w_q_last ? LOAD_K : WAIT_Q;
      end
      default: w_next = LOAD_K;
    endcase
  end

  // K buffer write, indexed by the token/head counters.
  // NOTE: the buffer has no reset; its contents are only read after a full
  // sequence has been written, so clearing it would add logic for nothing.
  always_ff @(posedge clk) begin
    if (w_k_fire) r_kbuf[r_k_tok][r_k_head] <= data_in_k;
  end

  // Full-precision dot product of the latched Q with key j of the same head.
  assign w_kvec = r_kbuf[r_j][r_out_head];
  always_comb begin
    w_acc  = '0;
    w_prod = '0;
    for (int d = 0; d < HEAD_DIM; d++) begin
      w_prod = $signed(r_q[d*IN_WIDTH +: IN_WIDTH]) * $signed(w_kvec[d*IN_WIDTH +: IN_WIDTH]);
      w_acc  = w_acc + ACC_W'(w_prod);
    end
  end

  // Floor-scale, saturate, then apply the causal mask to the future keys.
  assign w_shift = w_acc >>> SHIFT;
  always_comb begin
    if (w_shift > SAT_MAX)      w_score = SAT_MAX[OUT_WIDTH-1:0];
    else if (w_shift < SAT_MIN) w_score = SAT_MIN[OUT_WIDTH-1:0];
    else                        w_score = w_shift[OUT_WIDTH-1:0];
    if ((CAUSAL != 0) && (r_j > r_out_row)) w_score = SAT_MIN[OUT_WIDTH-1:0];
  end

  // Beat counters, Q latch, key index and the score row register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k_tok    <= '0;
      r_k_head   <= '0;
      r_q_tok    <= '0;
      r_q_head   <= '0;
      r_j        <= '0;
      r_q        <= '0;
      r_row      <= '0;
      r_out_head <= '0;
      r_out_row  <= '0;
    end else begin
      if (w_k_fire) begin
        if (r_k_head == HW'(NUM_HEADS-1)) begin
          r_k_head <= '0;
          r_k_tok  <= w_k_last ? '0 : r_k_tok + 1'b1;
        end else begin
          r_k_head <= r_k_head + 1'b1;
        end
      end
      if (w_q_fire) begin
        r_q        <= data_in_q;
        r_out_head <= r_q_head;
        r_out_row  <= r_q_tok;
        r_j        <= '0;
      end
      if (r_state == COMPUTE) begin
        r_row[r_j*OUT_WIDTH +: OUT_WIDTH] <= w_score;
        r_j <= w_j_last ? '0 : r_j + 1'b1;
      end
      if (w_out_fire) begin
        if (r_q_head == HW'(NUM_HEADS-1)) begin
          r_q_head <= '0;
          r_q_tok  <= w_q_last ? '0 : r_q_tok + 1'b1;
        end else begin
          r_q_head <= r_q_head + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fixed_mha_score.sv
// Bench for fixed_mha_score: a CAUSAL=0 and a CAUSAL=1 instance share the same
// stimulus, and every row is compared with an arithmetic reference model.
module tb_fixed_mha_score;
  localparam int IN_WIDTH  = 8;
  localparam int IN_FRAC   = 1;
  localparam int OUT_WIDTH = 8;
  localparam int OUT_FRAC  = 2;
  localparam int NH        = 2;
  localparam int SL        = 4;
  localparam int HD        = 2;
  localparam int SS        = 1;
  localparam int HW        = 1;
  localparam int SW        = 2;
  localparam int SH        = 2*IN_FRAC + SS - OUT_FRAC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [IN_WIDTH*HD-1:0] data_in_k = '0, data_in_q = '0;
  logic data_in_k_valid = 1'b0, data_in_q_valid = 1'b0, data_out_ready = 1'b0;

  logic k_ready0, q_ready0, valid0, k_loaded0;
  logic k_ready1, q_ready1, valid1, k_loaded1;
  logic [OUT_WIDTH*SL-1:0] dout0, dout1;
  logic [HW-1:0] head0, head1;
  logic [SW-1:0] row0, row1;

  int kmem [SL][NH][HD];
  int qmem [SL][NH][HD];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fixed_mha_score #(.IN_WIDTH(IN_WIDTH), .IN_FRAC_WIDTH(IN_FRAC), .OUT_WIDTH(OUT_WIDTH),
    .OUT_FRAC_WIDTH(OUT_FRAC), .NUM_HEADS(NH), .SEQ_LEN(SL), .HEAD_DIM(HD),
    .SCALE_SHIFT(SS), .CAUSAL(0)) dut (
    .clk(clk), .rst(rst),
    .data_in_k(data_in_k), .data_in_k_valid(data_in_k_valid), .data_in_k_ready(k_ready0),
    .data_in_q(data_in_q), .data_in_q_valid(data_in_q_valid), .data_in_q_ready(q_ready0),
    .data_out(dout0), .data_out_head(head0), .data_out_row(row0),
    .data_out_valid(valid0), .data_out_ready(data_out_ready), .k_loaded(k_loaded0));

  fixed_mha_score #(.IN_WIDTH(IN_WIDTH), .IN_FRAC_WIDTH(IN_FRAC), .OUT_WIDTH(OUT_WIDTH),
    .OUT_FRAC_WIDTH(OUT_FRAC), .NUM_HEADS(NH), .SEQ_LEN(SL), .HEAD_DIM(HD),
    .SCALE_SHIFT(SS), .CAUSAL(1)) dut_c (
    .clk(clk), .rst(rst),
    .data_in_k(data_in_k), .data_in_k_valid(data_in_k_valid), .data_in_k_ready(k_ready1),
    .data_in_q(data_in_q), .data_in_q_valid(data_in_q_valid), .data_in_q_ready(q_ready1),
    .data_out(dout1), .data_out_head(head1), .data_out_row(row1),
    .data_out_valid(valid1), .data_out_ready(data_out_ready), .k_loaded(k_loaded1));

  // Reference score: real-valued floor of acc / 2^SH, clamped, then masked.
  function automatic int ref_score(int i, int h, int j, bit causal);
    int acc = 0;
    int dv  = 1 << SH;
    int lo  = -(1 << (OUT_WIDTH-1));
    int hi  = (1 << (OUT_WIDTH-1)) - 1;
    int s;
    if (causal && j > i) return lo;
    for (int e = 0; e < HD; e++) acc += qmem[i][h][e] * kmem[j][h][e];
    s = (acc >= 0) ? acc / dv : -((-acc + dv - 1) / dv);
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s;
  endfunction

  function automatic logic [IN_WIDTH*HD-1:0] pack_vec(int t, int h, bit is_q);
    logic [IN_WIDTH*HD-1:0] v = '0;
    for (int e = 0; e < HD; e++)
      v[e*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(is_q ? qmem[t][h][e] : kmem[t][h][e]);
    return v;
  endfunction

  task automatic fill(int kv0, int kv1, int qv0, int qv1);
    for (int t = 0; t < SL; t++)
      for (int h = 0; h < NH; h++) begin
        kmem[t][h][0] = kv0; kmem[t][h][1] = kv1;
        qmem[t][h][0] = qv0; qmem[t][h][1] = qv1;
      end
  endtask

  task automatic fill_random();
    for (int t = 0; t < SL; t++)
      for (int h = 0; h < NH; h++)
        for (int e = 0; e < HD; e++) begin
          kmem[t][h][e] = int'($urandom_range(255)) - 128;
          qmem[t][h][e] = int'($urandom_range(255)) - 128;
        end
  endtask

  // Streams one sequence of K beats; optionally holds Q valid alongside.
  task automatic load_k_seq(bit q_noise);
    for (int t = 0; t < SL; t++)
      for (int h = 0; h < NH; h++) begin
        data_in_k       = pack_vec(t, h, 1'b0);
        data_in_k_valid = 1'b1;
        data_in_q_valid = q_noise && !(t == SL-1 && h == NH-1);
        data_in_q       = IN_WIDTH*HD'($urandom);
        n_cmp++;
        if (k_ready0 !== 1'b1 || q_ready0 !== 1'b0 || q_ready1 !== 1'b0) begin
          n_err++;
          $display("FAIL load_ready t=%0d h=%0d: k_ready=%b q_ready=%b/%b, required 1 0/0",
                   t, h, k_ready0, q_ready0, q_ready1);
        end
        @(negedge clk);
        data_in_k_valid = 1'b0;
        data_in_q_valid = 1'b0;
        repeat ($urandom_range(1)) @(negedge clk);
      end
    n_cmp++;
    if (k_loaded0 !== 1'b1 || k_loaded1 !== 1'b1 || k_ready0 !== 1'b0) begin
      n_err++;
      $display("FAIL k_loaded_set: k_loaded=%b/%b k_ready=%b, required 1/1 0",
               k_loaded0, k_loaded1, k_ready0);
    end
  endtask

  // Sends every Q beat of the sequence and checks each row; stall_row gets a
  // 5-cycle output stall with Q valid held high during it.
  task automatic run_q_seq(int stall_row);
    int n, lat, ns;
    logic [OUT_WIDTH*SL-1:0] snap;
    logic signed [OUT_WIDTH-1:0] got, ev;
    for (int r = 0; r < SL*NH; r++) begin
      int t = r / NH;
      int h = r % NH;
      data_in_q       = pack_vec(t, h, 1'b1);
      data_in_q_valid = 1'b1;
      n = 0;
      while (!q_ready0 && n < 50) begin @(negedge clk); n++; end
      n_cmp++;
      if (n >= 50 || k_loaded0 !== 1'b1) begin
        n_err++;
        $display("FAIL q_accept row=%0d: waited=%0d k_loaded=%b, required <50 1", r, n, k_loaded0);
      end
      @(negedge clk);
      data_in_q_valid = 1'b0;
      lat = 0;
      while (!valid0 && lat < 50) begin @(negedge clk); lat++; end
      n_cmp++;
      if (lat != SL || valid1 !== 1'b1 || q_ready0 !== 1'b0) begin
        n_err++;
        $display("FAIL latency row=%0d: cycles=%0d valid_c=%b q_ready=%b, required %0d 1 0",
                 r, lat, valid1, q_ready0, SL);
      end
      n_cmp++;
      if (head0 !== HW'(h) || row0 !== SW'(t) || head1 !== HW'(h) || row1 !== SW'(t)) begin
        n_err++;
        $display("FAIL row_id row=%0d: head=%0d/%0d row=%0d/%0d, required head=%0d row=%0d",
                 r, head0, head1, row0, row1, h, t);
      end
      for (int j = 0; j < SL; j++) begin
        got = dout0[j*OUT_WIDTH +: OUT_WIDTH];
        ev  = OUT_WIDTH'(ref_score(t, h, j, 1'b0));
        n_cmp++;
        if (got !== ev) begin
          n_err++;
          $display("FAIL score i=%0d h=%0d j=%0d: got %0d, required %0d", t, h, j, got, ev);
        end
        got = dout1[j*OUT_WIDTH +: OUT_WIDTH];
        ev  = OUT_WIDTH'(ref_score(t, h, j, 1'b1));
        n_cmp++;
        if (got !== ev) begin
          n_err++;
          $display("FAIL causal_score i=%0d h=%0d j=%0d: got %0d, required %0d", t, h, j, got, ev);
        end
      end
      ns   = (r == stall_row) ? 5 : int'($urandom_range(2));
      snap = dout0;
      for (int s = 0; s < ns; s++) begin
        if (r == stall_row) begin
          data_in_q_valid = 1'b1;
          data_in_q       = IN_WIDTH*HD'($urandom);
        end
        @(negedge clk);
        n_cmp++;
        if (dout0 !== snap || valid0 !== 1'b1 || q_ready0 !== 1'b0) begin
          n_err++;
          $display("FAIL stall row=%0d cyc=%0d: data=%h valid=%b q_ready=%b, required %h 1 0",
                   r, s, dout0, valid0, q_ready0, snap);
        end
      end
      data_in_q_valid = 1'b0;
      data_out_ready  = 1'b1;
      @(negedge clk);
      data_out_ready  = 1'b0;
      if (r == SL*NH-1) begin
        n_cmp++;
        if (k_ready0 !== 1'b1 || k_loaded0 !== 1'b0 || k_loaded1 !== 1'b0 || valid0 !== 1'b0) begin
          n_err++;
          $display("FAIL seq_end: k_ready=%b k_loaded=%b/%b valid=%b, required 1 0/0 0",
                   k_ready0, k_loaded0, k_loaded1, valid0);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (valid0 !== 1'b0 || k_loaded0 !== 1'b0 || q_ready0 !== 1'b0 || dout0 !== '0 ||
        dout1 !== '0 || head0 !== '0 || row0 !== '0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b k_loaded=%b q_ready=%b data=%h/%h head=%0d row=%0d, required all 0",
               valid0, k_loaded0, q_ready0, dout0, dout1, head0, row0);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (k_ready0 !== 1'b1 || k_ready1 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_k_ready: got %b/%b, required 1/1", k_ready0, k_ready1);
    end
  endtask

  task automatic test_base();
    fill(2, 2, 4, 4);
    load_k_seq(1'b1);
    run_q_seq(-1);
  endtask

  task automatic test_saturation();
    fill(127, 127, 127, 127);
    load_k_seq(1'b0);
    run_q_seq(-1);
    fill(-128, -128, 127, 127);
    load_k_seq(1'b0);
    run_q_seq(-1);
  endtask

  task automatic test_floor();
    fill(1, 2, 0, 0);
    for (int t = 0; t < SL; t++)
      for (int h = 0; h < NH; h++) begin
        qmem[t][h][0] = ((t + h) % 2 == 0) ? -1 : 1;
        qmem[t][h][1] = qmem[t][h][0];
      end
    load_k_seq(1'b0);
    run_q_seq(-1);
  endtask

  task automatic test_backpressure();
    fill_random();
    load_k_seq(1'b1);
    run_q_seq(3);
  endtask

  task automatic test_reset_mid_compute();
    fill_random();
    load_k_seq(1'b0);
    data_in_q       = pack_vec(0, 0, 1'b1);
    data_in_q_valid = 1'b1;
    @(negedge clk);
    data_in_q_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (valid0 !== 1'b0 || k_loaded0 !== 1'b0 || k_loaded1 !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: valid=%b k_loaded=%b/%b, required 0 0/0", valid0, k_loaded0, k_loaded1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (k_ready0 !== 1'b1 || q_ready0 !== 1'b0 || dout0 !== '0) begin
      n_err++;
      $display("FAIL post_reset: k_ready=%b q_ready=%b data=%h, required 1 0 0", k_ready0, q_ready0, dout0);
    end
    fill_random();
    load_k_seq(1'b0);
    run_q_seq(-1);
  endtask

  initial begin
    test_reset();
    test_base();
    test_saturation();
    test_floor();
    test_backpressure();
    test_reset_mid_compute();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fixed_mha_score.md
Name: fixed_mha_score

Overview:
Multi-head attention score engine producing scaled, optionally causal-masked S = Q·Kᵀ rows per head for the fixed-point attention datapath. It sits between the Q/K projection stage and softmax. It generalises the single-head score matmul with head count, sequence length, shift-based 1/sqrt(d) scaling, a causal mask and output saturation. K vectors are buffered once per sequence. Q vectors then stream in, and each yields one full score row.

Parameters:
IN_WIDTH, 8, Q/K element width (signed)
IN_FRAC_WIDTH, 1, Q/K fractional bits
OUT_WIDTH, 8, score width (signed)
OUT_FRAC_WIDTH, 2, score fractional bits
NUM_HEADS, 2, heads per token
SEQ_LEN, 4, tokens per sequence
HEAD_DIM, 2, elements per head vector
SCALE_SHIFT, 1, extra right shift applied to every score (scaling); constraint: 2*IN_FRAC_WIDTH+SCALE_SHIFT >= OUT_FRAC_WIDTH
CAUSAL, 0, 1 = mask scores where key index j > query index i

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
data_in_k  in  IN_WIDTH x HEAD_DIM  one K head vector
data_in_k_valid  in  1  K valid
data_in_k_ready  out  1  K ready
data_in_q  in  IN_WIDTH x HEAD_DIM  one Q head vector
data_in_q_valid  in  1  Q valid
data_in_q_ready  out  1  Q ready
data_out  out  OUT_WIDTH x SEQ_LEN  score row; element j = score vs key token j
data_out_head  out  clog2(NUM_HEADS) (min 1)  head of current row
data_out_row  out  clog2(SEQ_LEN) (min 1)  query token of current row
data_out_valid  out  1  row valid
data_out_ready  in  1  row accepted
k_loaded  out  1  K buffer full for current sequence

Behaviour:
- Beat order for K and Q is token-major, head-minor: (t0,h0),(t0,h1),...,(t1,h0),... There are SEQ_LEN*NUM_HEADS beats per sequence.
- FSM states: LOAD_K, WAIT_Q, COMPUTE, OUTPUT.
- Reset (rst=0, asynchronous): state=LOAD_K; all counters 0; data_in_k_ready=1 once released; data_in_q_ready=0; data_out_valid=0; data_out, data_out_head and data_out_row = 0; k_loaded=0. The K buffer contents are don't-care. Reset mid-operation discards any partial sequence.
- LOAD_K:
  - data_in_k_ready=1.
  - Each handshake writes buffer[token][head] and advances the counters.
  - On the last beat: go to WAIT_Q and set k_loaded=1 next cycle.
  - Q is never accepted in this state.
- WAIT_Q:
  - data_in_q_ready=1.
  - On handshake: latch Q, head h and token i from the Q counters; go to COMPUTE with j=0.
- COMPUTE:
  - One key per cycle, for j=0..SEQ_LEN-1.
  - acc = sum over HEAD_DIM of q[d]*buffer[j][h][d]. Use full precision: width 2*IN_WIDTH+clog2(HEAD_DIM), frac 2*IN_FRAC_WIDTH.
  - score = acc >>> (2*IN_FRAC_WIDTH+SCALE_SHIFT-OUT_FRAC_WIDTH). This is an arithmetic shift (floor toward -inf).
  - Saturate score to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and write it to row register element j.
  - If CAUSAL=1 and j>i, write -2^(OUT_WIDTH-1) instead.
  - After j=SEQ_LEN-1: go to OUTPUT.
- OUTPUT:
  - data_out_valid=1. data_out, data_out_head and data_out_row stay stable until data_out_ready=1.
  - On handshake, advance the Q counters.
  - If that was the last Q beat of the sequence: go to LOAD_K and clear k_loaded. Otherwise go to WAIT_Q.
- Latency: Q accept at cycle c → data_out_valid first high at c+SEQ_LEN+1.
  - Minimum row period is SEQ_LEN+2 cycles.
  - data_in_q_ready is low in COMPUTE and OUTPUT, so backpressure stalls Q.
- Ready signals depend only on state, never combinationally on valid.
- Simultaneous K and Q valid: only the one matching the current state is accepted.

Test Plan:
- Base params (IN frac1, OUT frac2, shift=1, HEAD_DIM=2).
  - Stimulus: all K elements = 2 (1.0), Q = 4 (2.0); acc=16; shift 1.
  - Required response: every score = 8 (2.0).
  - Checks: 8 rows with head/row order (0,0),(1,0),(0,1),...; k_loaded=1 throughout Q phase.
- Saturation.
  - Positive: Q=K=127 → all scores 127.
  - Negative: Q=127, K=-128 → all scores -128.
- Floor rounding.
  - Stimulus: acc = -3 (e.g. Q={-1,-1}, K={1,2}).
  - Required response: score -2. With acc = +3, score 1.
- CAUSAL=1 with the values of the base test.
  - Required response for row i=1: {8,8,-128,-128}. Row i=0: {8,-128,-128,-128}. Row i=3: all 8.
- Backpressure and protocol.
  - Hold data_out_ready=0 for 5 cycles: data_out stable, data_in_q_ready=0, no extra beats accepted.
  - Q valid presented during LOAD_K: not accepted.
  - After the last row, data_in_k_ready=1 for the next sequence.
- Reset mid-COMPUTE (rst low 1 cycle).
  - Required response: data_out_valid=0 and k_loaded=0 immediately (asynchronously). data_in_k_ready=1 after release.
  - A fresh sequence then produces the correct scores.
